mips_multicycle_sim: RTL

Parametrised multi-cycle MIPS instruction-set simulator core. It executes a program held in an internal instruction memory, one instruction per multi-state FSM pass. It extends the integer subset with BNE, J, shifts, logical immediates, LUI and HALT, and traps on faults. The bench preloads Instr_Mem (and optionally Data_Mem) hierarchically, then checks Reg_File, Data_Mem and the status ports.

---
 rtl/mips_sim_pkg.sv | 49 ++++
 rtl/mips_alu.sv | 32 +++
 rtl/mips_multicycle_sim.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/mips_sim_pkg.sv
// Shared encodings for the multi-cycle MIPS simulator core: opcodes, functs,
// FSM states, fault codes, ALU operations and decoded instruction classes.
package mips_sim_pkg;

    typedef enum logic [2:0] {
        ST_IDLE, ST_FETCH, ST_DECODE, ST_EXEC, ST_MEM, ST_WB, ST_HALT
    } state_t;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_NOR, ALU_SLT, ALU_SLL, ALU_SRL, ALU_LUI
    } alu_op_t;

    typedef enum logic [3:0] {
        K_RALU, K_IALU, K_LW, K_SW, K_BEQ, K_BNE, K_J, K_HALT, K_ILL
    } kind_t;

    // Second ALU operand: register B, sign-extended or zero-extended immediate
    typedef enum logic [1:0] {
        BS_REG, BS_SIMM, BS_ZIMM
    } bsel_t;

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_ILLEGAL = 2'd1;
    localparam logic [1:0] ERR_DADDR   = 2'd2;
    localparam logic [1:0] ERR_PC      = 2'd3;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_HALT  = 6'h3F;

    localparam logic [5:0] FN_SLL = 6'h00;
    localparam logic [5:0] FN_SRL = 6'h02;
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_NOR = 6'h27;
    localparam logic [5:0] FN_SLT = 6'h2A;

endpackage

// File: rtl/mips_alu.sv
// Combinational 32-bit ALU; all arithmetic wraps, SLT compares signed,
// shifts operate on B by shamt (SRL is logical).
module mips_alu
    import mips_sim_pkg::*;
(
    input  logic signed [31:0] a_i,
    input  logic signed [31:0] b_i,
    input  logic        [4:0]  shamt_i,
    input  alu_op_t            alu_op_i,
    output logic signed [31:0] result_o,
    output logic               zero_o
);

    always_comb begin
        result_o = '0;
        case (alu_op_i)
            ALU_ADD: result_o = a_i + b_i;
            ALU_SUB: result_o = a_i - b_i;
            ALU_AND: result_o = a_i & b_i;
            ALU_OR:  result_o = a_i | b_i;
            ALU_NOR: result_o = ~(a_i | b_i);
            ALU_SLT: result_o = (a_i < b_i) ? 32'sd1 : 32'sd0;
            ALU_SLL: result_o = b_i << shamt_i;
            ALU_SRL: result_o = $signed($unsigned(b_i) >> shamt_i);
            ALU_LUI: result_o = b_i << 16;
            default: result_o = '0;
        endcase
    end

    assign zero_o = (result_o == 32'sd0);

endmodule

// File: rtl/mips_multicycle_sim.sv
// Multi-cycle MIPS subset core: FETCH/DECODE/EXEC/MEM/WB FSM with internal
// instruction/data memories and register file; faults park the FSM in HALT.
module mips_multicycle_sim
    import mips_sim_pkg::*;
#(
    parameter int IMEM_DEPTH      = 256,
    parameter int DMEM_DEPTH      = 256,
    parameter int HALT_ON_ILLEGAL = 1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        run_i,
    output logic [31:0] pc_o,
    output logic        busy_o,
    output logic        halted_o,
    output logic [1:0]  err_o,
    output logic [31:0] retired_o
);

    localparam int IA_W = $clog2(IMEM_DEPTH);
    localparam int DA_W = $clog2(DMEM_DEPTH);
    localparam logic [29:0] IMEM_LIM = 30'(IMEM_DEPTH);
    localparam logic [29:0] DMEM_LIM = 30'(DMEM_DEPTH);

    // Instruction memory is loaded externally and never written by the core
    logic        [31:0] Instr_Mem [0:IMEM_DEPTH-1] = '{default: '0};
    logic        [31:0] Data_Mem  [0:DMEM_DEPTH-1];
    logic signed [31:0] Reg_File  [0:31];

    state_t             state_q;
    logic        [31:0] pc_q, ir_q, simm_q, zimm_q, mdr_q, retired_q;
    logic signed [31:0] a_q, b_q, alu_q;
    kind_t              kind_q;
    alu_op_t            alu_op_q;
    bsel_t              bsel_q;
    logic        [4:0]  dst_q;
    logic        [1:0]  err_q;

    kind_t              dec_kind;
    alu_op_t            dec_alu;
    bsel_t              dec_bsel;
    logic        [4:0]  dec_dst;

    logic signed [31:0] alu_b_d, alu_res_d, wb_d;
    logic               alu_zero_d, taken_d, dfault_d, retire_d;
    logic        [31:0] pc_plus4_d, pc_next_d, ea_d;

    always_comb begin
        dec_kind = K_ILL;
        dec_alu  = ALU_ADD;
        dec_bsel = BS_REG;
        dec_dst  = ir_q[15:11];
        case (ir_q[31:26])
            OP_RTYPE: begin
                dec_kind = K_RALU;
                case (ir_q[5:0])
                    FN_ADD:  dec_alu = ALU_ADD;
                    FN_SUB:  dec_alu = ALU_SUB;
                    FN_AND:  dec_alu = ALU_AND;
                    FN_OR:   dec_alu = ALU_OR;
                    FN_NOR:  dec_alu = ALU_NOR;
                    FN_SLT:  dec_alu = ALU_SLT;
                    FN_SLL:  dec_alu = ALU_SLL;
                    FN_SRL:  dec_alu = ALU_SRL;
                    default: dec_kind = K_ILL;
                endcase
            end
            OP_ADDI: begin dec_kind = K_IALU; dec_bsel = BS_SIMM; dec_dst = ir_q[20:16]; end
            OP_SLTI: begin dec_kind = K_IALU; dec_alu = ALU_SLT; dec_bsel = BS_SIMM; dec_dst = ir_q[20:16]; end
            OP_ANDI: begin dec_kind = K_IALU; dec_alu = ALU_AND; dec_bsel = BS_ZIMM; dec_dst = ir_q[20:16]; end
            OP_ORI:  begin dec_kind = K_IALU; dec_alu = ALU_OR;  dec_bsel = BS_ZIMM; dec_dst = ir_q[20:16]; end
            OP_LUI:  begin dec_kind = K_IALU; dec_alu = ALU_LUI; dec_bsel = BS_ZIMM; dec_dst = ir_q[20:16]; end
            OP_LW:   begin dec_kind = K_LW; dec_dst = ir_q[20:16]; end
            OP_SW:   dec_kind = K_SW;
            OP_BEQ:  begin dec_kind = K_BEQ; dec_alu = ALU_SUB; end
            OP_BNE:  begin dec_kind = K_BNE; dec_alu = ALU_SUB; end
            OP_J:    dec_kind = K_J;
            OP_HALT: dec_kind = K_HALT;
            default: dec_kind = K_ILL;
        endcase
    end

    assign alu_b_d = (bsel_q == BS_SIMM) ? $signed(simm_q) :
                     (bsel_q == BS_ZIMM) ? $signed(zimm_q) : b_q;

    mips_alu u_alu (
        .a_i      (a_q),
        .b_i      (alu_b_d),
        .shamt_i  (ir_q[10:6]),
        .alu_op_i (alu_op_q),
        .result_o (alu_res_d),
        .zero_o   (alu_zero_d)
    );

    assign pc_plus4_d = pc_q + 32'd4;
    assign ea_d       = $unsigned(a_q) + simm_q;
    assign dfault_d   = (ea_d[1:0] != 2'b00) || (ea_d[31:2] >= DMEM_LIM);
    assign taken_d    = ((kind_q == K_BEQ) && alu_zero_d) || ((kind_q == K_BNE) && !alu_zero_d);
    assign wb_d       = (kind_q == K_LW) ? $signed(mdr_q) : alu_q;

    // Retirement point and next PC for whichever state finishes the instruction
    always_comb begin
        retire_d  = 1'b0;
        pc_next_d = pc_plus4_d;
        case (state_q)
            ST_DECODE: retire_d = (dec_kind == K_ILL) && (HALT_ON_ILLEGAL == 0);
            ST_EXEC: begin
                retire_d = kind_q inside {K_BEQ, K_BNE, K_J};
                if (kind_q == K_J)
                    pc_next_d = {pc_plus4_d[31:28], ir_q[25:0], 2'b00};
                else if (taken_d)
                    pc_next_d = pc_plus4_d + {simm_q[29:0], 2'b00};
            end
            ST_MEM:  retire_d = (kind_q == K_SW) && !dfault_d;
            ST_WB:   retire_d = 1'b1;
            default: retire_d = 1'b0;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= ST_IDLE;
            pc_q      <= '0;
            ir_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            simm_q    <= '0;
            zimm_q    <= '0;
            alu_q     <= '0;
            mdr_q     <= '0;
            kind_q    <= K_ILL;
            alu_op_q  <= ALU_ADD;
            bsel_q    <= BS_REG;
            dst_q     <= '0;
            err_q     <= ERR_NONE;
            retired_q <= '0;
            for (int i = 0; i < 32; i++) Reg_File[i] <= '0;
            for (int i = 0; i < DMEM_DEPTH; i++) Data_Mem[i] <= '0;
        end else begin
            case (state_q)
                ST_IDLE: if (run_i) state_q <= ST_FETCH;
                ST_FETCH: begin
                    if ((pc_q[1:0] != 2'b00) || (pc_q[31:2] >= IMEM_LIM)) begin
                        state_q <= ST_HALT;
                        err_q   <= ERR_PC;
                    end else begin
                        ir_q    <= Instr_Mem[pc_q[IA_W+1:2]];
                        state_q <= ST_DECODE;
                    end
                end
                ST_DECODE: begin
                    a_q      <= Reg_File[ir_q[25:21]];
                    b_q      <= Reg_File[ir_q[20:16]];
                    simm_q   <= {{16{ir_q[15]}}, ir_q[15:0]};
                    zimm_q   <= {16'h0000, ir_q[15:0]};
                    kind_q   <= dec_kind;
                    alu_op_q <= dec_alu;
                    bsel_q   <= dec_bsel;
                    dst_q    <= dec_dst;
                    if (dec_kind == K_HALT) begin
                        state_q <= ST_HALT;
                        err_q   <= ERR_NONE;
                    end else if (dec_kind == K_ILL) begin
                        if (HALT_ON_ILLEGAL != 0) begin
                            state_q <= ST_HALT;
                            err_q   <= ERR_ILLEGAL;
                        end
                    end else begin
                        state_q <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    alu_q <= alu_res_d;
                    if ((kind_q == K_LW) || (kind_q == K_SW))
                        state_q <= ST_MEM;
                    else if ((kind_q == K_RALU) || (kind_q == K_IALU))
                        state_q <= ST_WB;
                end
                ST_MEM: begin
                    if (dfault_d) begin
                        state_q <= ST_HALT;
                        err_q   <= ERR_DADDR;
                    end else if (kind_q == K_LW) begin
                        mdr_q   <= Data_Mem[ea_d[DA_W+1:2]];
                        state_q <= ST_WB;
                    end else begin
                        Data_Mem[ea_d[DA_W+1:2]] <= b_q;
                    end
                end
                ST_WB: if (dst_q != 5'd0) Reg_File[dst_q] <= wb_d;
                default: state_q <= state_q;
            endcase
            if (retire_d) begin
                pc_q      <= pc_next_d;
                retired_q <= retired_q + 32'd1;
                state_q   <= run_i ? ST_FETCH : ST_IDLE;
            end
        end
    end

    assign pc_o      = pc_q;
    assign busy_o    = (state_q != ST_IDLE) && (state_q != ST_HALT);
    assign halted_o  = (state_q == ST_HALT);
    assign err_o     = err_q;
    assign retired_o = retired_q;

endmodule
